// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared types and constants for the program loader
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         MAX_LEN   = 32;

endpackage

// File: rtl/cksum8.sv
// rtl/cksum8.sv - 8-bit wrap-around checksum accumulator with zero detect (used when PROG_LOADER_CKSUM_EN)
module cksum8 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       seed_i,
  input  logic       acc_i,
  input  logic [7:0] data_i,
  output logic       zero_o
);

  logic [7:0] sum_q, sum_d;
  logic [7:0] nxt_sum;

  // sum including the byte currently presented; the check byte is tested against this
  assign nxt_sum = sum_q + data_i;
  assign zero_o  = (nxt_sum == 8'h00);

  // clear has priority, then seed with the length byte, then accumulate
  always_comb begin
    sum_d = sum_q;
    if (clr_i)       sum_d = 8'h00;
    else if (seed_i) sum_d = data_i;
    else if (acc_i)  sum_d = nxt_sum;
  end

  // running sum register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sum_q <= 8'h00;
    else       sum_q <= sum_d;
  end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader for the 32x8 program memory; PROG_LOADER_CKSUM_EN enables the CHK byte
import prog_loader_pkg::*;

module prog_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              cpu_rst_o,
  output logic              done_o,
  output logic              err_o
);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept;
  logic              is_sync;
  logic              len_bad;

`ifdef PROG_LOADER_CKSUM_EN
  logic ck_clr, ck_seed, ck_acc, ck_zero;

  cksum8 u_cksum8 (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (ck_clr),
    .seed_i (ck_seed),
    .acc_i  (ck_acc),
    .data_i (rx_data_i),
    .zero_o (ck_zero)
  );
`endif

  // only DONE refuses input, so the stream is stalled for exactly one cycle per frame
  assign rx_ready_o = (state_q != ST_DONE);
  assign accept     = rx_valid_i & rx_ready_o;
  assign is_sync    = (rx_data_i == SYNC_BYTE);
  assign len_bad    = (rx_data_i == '0) || (rx_data_i > DATA_W'(MAX_LEN));

  // next-state and registered-output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    cpu_rst_d  = cpu_rst_q;
    done_d     = 1'b0;
    err_d      = err_q;
`ifdef PROG_LOADER_CKSUM_EN
    ck_clr     = 1'b0;
    ck_seed    = 1'b0;
    ck_acc     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef PROG_LOADER_CKSUM_EN
        ck_clr = 1'b1;
`endif
        if (accept && is_sync) begin
          state_d   = ST_LEN;
          cpu_rst_d = 1'b1;
        end
      end
      ST_LEN: begin
        if (accept) begin
          if (len_bad) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = ST_DATA;
            len_d   = rx_data_i[ADDR_W:0];
            cnt_d   = '0;
`ifdef PROG_LOADER_CKSUM_EN
            ck_seed = 1'b1;
`endif
          end
        end
      end
      ST_DATA: begin
        // SYNC_BYTE is ordinary payload here
        if (accept) begin
          mem_we_d   = 1'b1;
          mem_addr_d = cnt_q[ADDR_W-1:0];
          mem_data_d = rx_data_i;
          cnt_d      = cnt_q + 1'b1;
`ifdef PROG_LOADER_CKSUM_EN
          ck_acc     = 1'b1;
          if (cnt_d == len_q) state_d = ST_CHK;
`else
          if (cnt_d == len_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
`endif
        end
      end
`ifdef PROG_LOADER_CKSUM_EN
      ST_CHK: begin
        if (accept) begin
          if (ck_zero) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
`endif
      ST_DONE: begin
        state_d   = ST_IDLE;
        cpu_rst_d = 1'b0;
      end
      ST_ERR: begin
        // CPU stays held; a partially written image must never run
        if (accept && is_sync) begin
          state_d = ST_LEN;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign cpu_rst_o  = cpu_rst_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule
